// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer: owns HI/LO and retires mult/div results after a fixed count.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES busy cycles; mthi/mtlo write the same edge.
// Backpressure: busy=1 while counting; any start seen during RUN is dropped, so upstream stalls on busy|start.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset, clears all state
//   start        E-stage op valid, qualified by md_op
//   md_op[2:0]   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A[31:0]      rs operand (dividend / multiplicand / mt source)
//   B[31:0]      rt operand (divisor / multiplier)
//   busy         registered, high while a mult/div is counting
//   HI[31:0]     HI architectural register
//   LO[31:0]     LO architectural register
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] LP_MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV_N  = 4'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_div_zero;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_t_hi;
    logic [31:0] r_t_lo;

    logic [63:0] w_a_sx;
    logic [63:0] w_b_sx;
    logic [63:0] w_a_zx;
    logic [63:0] w_b_zx;
    logic [63:0] w_mul_s;
    logic [63:0] w_mul_u;
    logic        w_b_zero;
    logic [31:0] w_b_safe;
    logic [31:0] w_quo_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quo_u;
    logic [31:0] w_rem_u;

    // Operands are widened explicitly so the 64-bit product is formed at full width.
    assign w_a_sx  = {{32{A[31]}}, A};
    assign w_b_sx  = {{32{B[31]}}, B};
    assign w_a_zx  = {32'd0, A};
    assign w_b_zx  = {32'd0, B};
    assign w_mul_s = $unsigned($signed(w_a_sx) * $signed(w_b_sx));
    assign w_mul_u = w_a_zx * w_b_zx;

    // Divide by a harmless 1 when B==0; the result is discarded at commit anyway,
    // this only keeps X out of the temp registers.
    assign w_b_zero = (B == 32'd0);
    assign w_b_safe = w_b_zero ? 32'd1 : B;
    assign w_quo_s  = $unsigned($signed(A) / $signed(w_b_safe));
    assign w_rem_s  = $unsigned($signed(A) % $signed(w_b_safe));
    assign w_quo_u  = A / w_b_safe;
    assign w_rem_u  = A % w_b_safe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_busy     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_t_hi     <= 32'd0;
            r_t_lo     <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (md_op)
                            OP_MULT: begin
                                {r_t_hi, r_t_lo} <= w_mul_s;
                                r_div_zero       <= 1'b0;
                                r_cnt            <= LP_MULT_N;
                                r_busy           <= 1'b1;
                                r_state          <= ST_RUN;
                            end
                            OP_MULTU: begin
                                {r_t_hi, r_t_lo} <= w_mul_u;
                                r_div_zero       <= 1'b0;
                                r_cnt            <= LP_MULT_N;
                                r_busy           <= 1'b1;
                                r_state          <= ST_RUN;
                            end
                            OP_DIV: begin
                                r_t_hi     <= w_rem_s;
                                r_t_lo     <= w_quo_s;
                                r_div_zero <= w_b_zero;
                                r_cnt      <= LP_DIV_N;
                                r_busy     <= 1'b1;
                                r_state    <= ST_RUN;
                            end
                            OP_DIVU: begin
                                r_t_hi     <= w_rem_u;
                                r_t_lo     <= w_quo_u;
                                r_div_zero <= w_b_zero;
                                r_cnt      <= LP_DIV_N;
                                r_busy     <= 1'b1;
                                r_state    <= ST_RUN;
                            end
                            OP_MTHI: r_hi <= A;
                            OP_MTLO: r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored here, including on the commit edge.
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        if (!r_div_zero) begin
                            r_hi <= r_t_hi;
                            r_lo <= r_t_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit_ctrl.sv
module tb_md_unit_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int vectors    = 0;
    int miscompares = 0;

    // Reference architectural state
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected busy duration from the op table.
    function automatic int exp_busy(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 5;
        if (op == 3'd3 || op == 3'd4) return 10;
        return 0;
    endfunction

    // Architectural effect of one accepted op, computed from sign/magnitude rules.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ma, mb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin
                p = 64'(sa * sb);
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            3'd2: begin
                p = 64'({32'd0, a}) * 64'({32'd0, b});
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            3'd3: if (b != 0) begin
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                q = ma / mb;
                r = ma - q * mb;
                if ((sa < 0) != (sb < 0)) q = -q;
                if (sa < 0) r = -r;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            3'd4: if (b != 0) begin
                m_lo = a / b; m_hi = a % b;
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Present one op for one edge, then scramble operands and count busy cycles.
    // Entered and left at #1 after a rising edge.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cycles);
        start = 1'b1; md_op = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
        busy_cycles = 0;
        while (busy && busy_cycles < 40) begin
            @(posedge clk); #1;
            busy_cycles++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        vectors++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b HI=%h LO=%h, required 0/0/0", busy, HI, LO);
        end
        // mult 7*6, reset asserted asynchronously two cycles in
        start = 1'b1; md_op = 3'd1; A = 32'd7; B = 32'd6;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_midop_async: busy=%b HI=%h LO=%h, required 0/0/0", busy, HI, LO);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (busy) n++;
        end
        vectors++;
        if (n != 0 || HI !== 32'd0 || LO !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_discard: busy_cycles=%0d HI=%h LO=%h, required 0/0/0", n, HI, LO);
        end
    endtask

    task automatic test_mult();
        int n;
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, n);
        vectors++;
        if (n != 5 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
            miscompares++;
            $display("FAIL mult_neg: busy=%0d HI=%h LO=%h, required 5 ffffffff fffffffa", n, HI, LO);
        end
        do_op(3'd2, 32'hFFFF_FFFE, 32'd3, n);
        vectors++;
        if (n != 5 || HI !== 32'h0000_0002 || LO !== 32'hFFFF_FFFA) begin
            miscompares++;
            $display("FAIL multu: busy=%0d HI=%h LO=%h, required 5 00000002 fffffffa", n, HI, LO);
        end
    endtask

    task automatic test_div();
        int n;
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, n);
        vectors++;
        if (n != 10 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            miscompares++;
            $display("FAIL div_neg: busy=%0d HI=%h LO=%h, required 10 ffffffff fffffffd", n, HI, LO);
        end
        do_op(3'd4, 32'd7, 32'd2, n);
        vectors++;
        if (n != 10 || HI !== 32'd1 || LO !== 32'd3) begin
            miscompares++;
            $display("FAIL divu: busy=%0d HI=%h LO=%h, required 10 1 3", n, HI, LO);
        end
    endtask

    task automatic test_div_zero();
        int n;
        do_op(3'd5, 32'h11, 32'd0, n);
        do_op(3'd6, 32'h22, 32'd0, n);
        vectors++;
        if (n != 0 || HI !== 32'h11 || LO !== 32'h22) begin
            miscompares++;
            $display("FAIL mt_preload: busy=%0d HI=%h LO=%h, required 0 11 22", n, HI, LO);
        end
        do_op(3'd3, 32'd5, 32'd0, n);
        vectors++;
        if (n != 10 || HI !== 32'h11 || LO !== 32'h22) begin
            miscompares++;
            $display("FAIL div_by_zero: busy=%0d HI=%h LO=%h, required 10 11 22", n, HI, LO);
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        do_reset();
        start = 1'b1; md_op = 3'd1; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        // Hold an mthi request through every busy cycle, commit edge included.
        start = 1'b1; md_op = 3'd5; A = 32'h0000_DEAD; B = 32'd0;
        n = 1;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            if (busy) n++;
        end
        start = 1'b0;
        vectors++;
        if (n != 5 || HI !== 32'd0 || LO !== 32'd12) begin
            miscompares++;
            $display("FAIL start_while_busy: busy=%0d HI=%h LO=%h, required 5 0 c", n, HI, LO);
        end
        do_op(3'd5, 32'h0000_DEAD, 32'd0, n);
        vectors++;
        if (n != 0 || busy !== 1'b0 || HI !== 32'h0000_DEAD || LO !== 32'd12) begin
            miscompares++;
            $display("FAIL mthi_reissue: busy=%0d HI=%h LO=%h, required 0 dead c", n, HI, LO);
        end
        m_hi = 32'h0000_DEAD; m_lo = 32'd12;
    endtask

    task automatic test_back_to_back();
        int n;
        do_op(3'd1, 32'd100, 32'hFFFF_FFFF, n);
        // do_op returns in the first cycle busy reads 0: mult must already be visible.
        vectors++;
        if (n != 5 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FF9C) begin
            miscompares++;
            $display("FAIL b2b_mult: busy=%0d HI=%h LO=%h, required 5 ffffffff ffffff9c", n, HI, LO);
        end
        do_op(3'd4, 32'd1000, 32'd7, n);
        vectors++;
        if (n != 10 || HI !== 32'd6 || LO !== 32'd142) begin
            miscompares++;
            $display("FAIL b2b_divu: busy=%0d HI=%h LO=%h, required 10 6 8e", n, HI, LO);
        end
        m_hi = 32'd6; m_lo = 32'd142;
    endtask

    task automatic test_random();
        int          n;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 50));
            if (op == 3'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            if ($urandom_range(0, 4) == 0) begin
                // Idle cycle with a garbage op: nothing may change.
                start = 1'b0; md_op = op; A = a; B = b;
                @(posedge clk); #1;
                n = busy ? 1 : 0;
            end else begin
                do_op(op, a, b, n);
                model_apply(op, a, b);
                if (n != exp_busy(op)) begin
                    miscompares++;
                    $display("FAIL rand_busy[%0d]: op=%0d busy_cycles=%0d required %0d", i, op, n, exp_busy(op));
                end
            end
            vectors++;
            if (HI !== m_hi || LO !== m_lo || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_hilo[%0d]: op=%0d a=%h b=%h HI=%h LO=%h busy=%b, required %h %h 0",
                         i, op, a, b, HI, LO, busy, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        #12;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
